// File: rtl/ooo_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : ooo_issue_queue
// Purpose  : In-order issue FIFO between decode and execute. The head issues
//            only when its functional unit is free and execute is not stalled.
//            Optional same-cycle bypass when empty: OOO_ISSUE_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module ooo_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 256
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ENTRY_W-1:0]           in_entry,
  input  logic [1:0]                   in_fu,
  input  logic                         ex_stall,
  input  logic [3:0]                   fu_busy,
  output logic                         out_valid,
  output logic [ENTRY_W-1:0]           out_entry,
  output logic [1:0]                   out_fu,
  output logic                         dispatch,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [1:0]         fu_q  [DEPTH];

  logic push;
  logic bypass;
  logic bypass_hit;
  logic wr_en;
  logic rd_adv;

  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign push     = in_valid & in_ready & ~flush;

`ifdef OOO_ISSUE_BYPASS_EN
  assign bypass = push & (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = (count_q != '0) | bypass;
  assign out_entry = bypass ? in_entry : mem_q[rd_ptr_q];
  assign out_fu    = bypass ? in_fu    : fu_q[rd_ptr_q];
  assign dispatch  = out_valid & ~ex_stall & ~fu_busy[out_fu] & ~flush;
  assign count     = count_q;

  // A bypassed entry that issues immediately never touches storage.
  assign bypass_hit = bypass & dispatch;
  assign wr_en      = push & ~bypass_hit;
  assign rd_adv     = dispatch & ~bypass_hit;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_adv);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_adv);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is never cleared; validity is tracked by count alone.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_entry;
      fu_q[wr_ptr_q]  <= in_fu;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ooo_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ooo_issue_queue
// Purpose  : Directed plus randomized checks of ooo_issue_queue against a
//            queue-based reference model (honours OOO_ISSUE_BYPASS_EN).
// Revision : 1.0
// ============================================================================
module tb_ooo_issue_queue;

  localparam int DEPTH   = 4;
  localparam int ENTRY_W = 256;
  localparam int CNT_W   = $clog2(DEPTH+1);

`ifdef OOO_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               CLK = 1'b0;
  logic               RST;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [ENTRY_W-1:0] in_entry;
  logic [1:0]         in_fu;
  logic               ex_stall;
  logic [3:0]         fu_busy;
  logic               out_valid;
  logic [ENTRY_W-1:0] out_entry;
  logic [1:0]         out_fu;
  logic               dispatch;
  logic [CNT_W-1:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  // Each element is {fu, payload}, oldest at index 0.
  logic [ENTRY_W+1:0] mq [$];

  ooo_issue_queue #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_entry(in_entry), .in_fu(in_fu),
    .ex_stall(ex_stall), .fu_busy(fu_busy),
    .out_valid(out_valid), .out_entry(out_entry), .out_fu(out_fu),
    .dispatch(dispatch), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [ENTRY_W-1:0] obs, input logic [ENTRY_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] rand_payload();
    logic [ENTRY_W-1:0] v;
    for (int i = 0; i < ENTRY_W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock cycle: apply inputs, check combinational view against the model,
  // then advance the model across the rising edge.
  task automatic cycle(input logic rst, input logic fl, input logic v,
                       input logic [ENTRY_W-1:0] e, input logic [1:0] f,
                       input logic st, input logic [3:0] busy, input bit check);
    int  n;
    bit  exp_ready, exp_push, exp_byp, exp_ov, exp_disp;
    logic [ENTRY_W+1:0] head;
    @(negedge CLK);
    RST = rst; flush = fl; in_valid = v; in_entry = e; in_fu = f;
    ex_stall = st; fu_busy = busy;
    #1;
    n         = mq.size();
    exp_ready = (n < DEPTH);
    exp_push  = v && exp_ready && !fl;
    exp_byp   = BYP && (n == 0) && exp_push;
    exp_ov    = (n != 0) || exp_byp;
    head      = exp_byp ? {f, e} : ((n != 0) ? mq[0] : '0);
    exp_disp  = exp_ov && !st && !busy[head[ENTRY_W+1:ENTRY_W]] && !fl;
    if (check) begin
      chk("in_ready",  ENTRY_W'(in_ready),  ENTRY_W'(exp_ready));
      chk("out_valid", ENTRY_W'(out_valid), ENTRY_W'(exp_ov));
      chk("dispatch",  ENTRY_W'(dispatch),  ENTRY_W'(exp_disp));
      chk("count",     ENTRY_W'(count),     ENTRY_W'(n));
      if (exp_ov) begin
        chk("out_entry", out_entry,          head[ENTRY_W-1:0]);
        chk("out_fu",    ENTRY_W'(out_fu),   ENTRY_W'(head[ENTRY_W+1:ENTRY_W]));
      end
    end
    @(posedge CLK);
    if (rst || fl) begin
      mq.delete();
    end else if (!(exp_byp && exp_disp)) begin
      if (exp_disp) void'(mq.pop_front());
      if (exp_push) mq.push_back({f, e});
    end
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; in_entry = '0; in_fu = '0;
    ex_stall = 1'b0; fu_busy = '0;

    cycle(1, 0, 0, '0, 0, 0, 4'h0, 0);
    cycle(1, 0, 0, '0, 0, 0, 4'h0, 0);
    mq.delete();
    cycle(0, 0, 0, '0, 0, 1, 4'h0, 1);

    // Fill to full under stall, then a fifth offer that must be refused.
    for (int i = 1; i <= 4; i++) cycle(0, 0, 1, ENTRY_W'(i), 0, 1, 4'h0, 1);
    cycle(0, 0, 1, ENTRY_W'(5), 0, 1, 4'h0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, '0, 0, 0, 4'h0, 1);

    // Continuous push/dispatch across pointer wrap.
    for (int i = 0; i < 11; i++) cycle(0, 0, 1, ENTRY_W'(16'h100 + i), 2'(i), 0, 4'h0, 1);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, '0, 0, 0, 4'h0, 1);

    // Busy head blocks a younger free-unit entry.
    cycle(0, 0, 1, ENTRY_W'(8'h20), 2, 1, 4'h0, 1);
    cycle(0, 0, 1, ENTRY_W'(8'h21), 0, 1, 4'h0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 0, 0, 4'b0100, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 0, 0, 4'h0, 1);

    // Flush with a concurrent push.
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, ENTRY_W'(8'h30 + i), 3, 1, 4'h0, 1);
    cycle(0, 1, 1, ENTRY_W'(8'h3F), 1, 0, 4'h0, 1);
    cycle(0, 0, 0, '0, 0, 0, 4'h0, 1);

    // Empty-queue push: bypass issues immediately, otherwise one cycle later.
    cycle(0, 0, 1, ENTRY_W'(8'hAA), 1, 0, 4'h0, 1);
    cycle(0, 0, 0, '0, 0, 0, 4'h0, 1);
    cycle(0, 0, 0, '0, 0, 0, 4'h0, 1);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 9) < 7), rand_payload(), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0),
            {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)}, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
